// File: rtl/ervp_register_file_mr1w_clear.sv
// Multi-read, single-write register file with per-subword write mask and a background clear.
// Define ERVP_REGFILE_BYPASS_EN to forward same-cycle writes and in-flight clears to the read ports.
module ervp_register_file_mr1w_clear #(
    parameter int DEPTH      = 8,
    parameter int WIDTH      = 32,
    parameter int BW_INDEX   = 3,
    parameter int NUM_RPORT  = 2,
    parameter int BW_SUBWORD = 8,
    localparam int NUM_SUBWORD = (WIDTH + BW_SUBWORD - 1) / BW_SUBWORD
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BW_INDEX-1:0]           windex,
    input  logic                          wenable,
    input  logic [NUM_SUBWORD-1:0]        wpermit,
    input  logic [WIDTH-1:0]              wdata,
    output logic                          wready,
    input  logic [NUM_RPORT*BW_INDEX-1:0] rindex_list,
    input  logic [NUM_RPORT-1:0]          renable_list,
    output logic [NUM_RPORT*WIDTH-1:0]    rdata_list_synch,
    output logic [NUM_RPORT-1:0]          rvalid_list,
    input  logic                          clear_request,
    output logic                          clear_busy,
    output logic                          clear_done,
    output logic [1:0]                    clear_state_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [BW_INDEX-1:0] LAST_IDX  = BW_INDEX'(DEPTH - 1);
    localparam logic [BW_INDEX:0]   DEPTH_EXT = (BW_INDEX + 1)'(DEPTH);

    logic [1:0]                       state_q, state_d;
    logic [BW_INDEX-1:0]              cnt_q, cnt_d;
    logic [WIDTH-1:0]                 mem_q [DEPTH];
    logic [WIDTH-1:0]                 mem_d [DEPTH];
    logic [NUM_RPORT-1:0][WIDTH-1:0]  rdata_q, rdata_d;
    logic [NUM_RPORT-1:0]             rvalid_q;
    logic [WIDTH-1:0]                 wmask;
    logic                             wr_en;
    logic [BW_INDEX-1:0]              rd_idx  [NUM_RPORT];
    logic [WIDTH-1:0]                 rd_word [NUM_RPORT];

    assign wready           = (state_q == ST_IDLE);
    assign clear_busy       = (state_q != ST_IDLE);
    assign clear_done       = (state_q == ST_DONE);
    assign clear_state_o    = state_q;
    assign rdata_list_synch = rdata_q;
    assign rvalid_list      = rvalid_q;

    // Out-of-range indices are dropped here so they never reach the array.
    assign wr_en = wenable && wready && ({1'b0, windex} < DEPTH_EXT);

    always_comb begin
        wmask = '0;
        for (int b = 0; b < WIDTH; b++) begin
            wmask[b] = wpermit[b / BW_SUBWORD];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_request) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The clear never overlaps a user write: wready is low outside IDLE.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            mem_d[e] = mem_q[e];
            if (wr_en && (windex == BW_INDEX'(e))) begin
                mem_d[e] = (mem_q[e] & ~wmask) | (wdata & wmask);
            end
            if ((state_q == ST_CLEAR) && (cnt_q == BW_INDEX'(e))) begin
                mem_d[e] = '0;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RPORT; p++) begin
            rd_idx[p]  = rindex_list[BW_INDEX*p +: BW_INDEX];
            rd_word[p] = '0;
            for (int e = 0; e < DEPTH; e++) begin
                if (rd_idx[p] == BW_INDEX'(e)) begin
                    rd_word[p] = mem_q[e];
                end
            end
`ifdef ERVP_REGFILE_BYPASS_EN
            if (wr_en && (rd_idx[p] == windex)) begin
                rd_word[p] = (rd_word[p] & ~wmask) | (wdata & wmask);
            end
            if ((state_q == ST_CLEAR) && (rd_idx[p] == cnt_q)) begin
                rd_word[p] = '0;
            end
`endif
            rdata_d[p] = renable_list[p] ? rd_word[p] : rdata_q[p];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= renable_list;
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= mem_d[e];
            end
        end
    end

endmodule

// File: tb/tb_ervp_register_file_mr1w_clear.sv
// Directed and random stimulus for the register file, checked against an array/counter reference model.
module tb_ervp_register_file_mr1w_clear;

    localparam int DEPTH      = 6;
    localparam int WIDTH      = 32;
    localparam int BW_INDEX   = 3;
    localparam int NUM_RPORT  = 2;
    localparam int BW_SUBWORD = 8;
    localparam int NSW        = 4;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [BW_INDEX-1:0]           windex;
    logic                          wenable;
    logic [NSW-1:0]                wpermit;
    logic [WIDTH-1:0]              wdata;
    logic                          wready;
    logic [NUM_RPORT*BW_INDEX-1:0] rindex_list;
    logic [NUM_RPORT-1:0]          renable_list;
    logic [NUM_RPORT*WIDTH-1:0]    rdata_list_synch;
    logic [NUM_RPORT-1:0]          rvalid_list;
    logic                          clear_request;
    logic                          clear_busy;
    logic                          clear_done;
    logic [1:0]                    clear_state_o;

    ervp_register_file_mr1w_clear #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .BW_INDEX(BW_INDEX),
        .NUM_RPORT(NUM_RPORT), .BW_SUBWORD(BW_SUBWORD)
    ) dut (
        .clk(clk), .rst(rst),
        .windex(windex), .wenable(wenable), .wpermit(wpermit), .wdata(wdata), .wready(wready),
        .rindex_list(rindex_list), .renable_list(renable_list),
        .rdata_list_synch(rdata_list_synch), .rvalid_list(rvalid_list),
        .clear_request(clear_request), .clear_busy(clear_busy), .clear_done(clear_done),
        .clear_state_o(clear_state_o)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model: array contents, clear position (-1 idle, 0..DEPTH-1 clearing, DEPTH done)
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] ref_mem [DEPTH];
    int          clr_pos  = -1;
    logic [31:0] last_rd [NUM_RPORT];
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] perm);
        logic [31:0] v;
        v = old;
        for (int s = 0; s < NSW; s++) begin
            if (perm[s]) v[8*s +: 8] = wd[8*s +: 8];
        end
        return v;
    endfunction

    function automatic logic [31:0] model_rd(input int idx, input bit wacc, input int widx,
                                             input logic [3:0] perm, input logic [31:0] wd);
        logic [31:0] v;
        if (idx >= DEPTH) return 32'h0;
        v = ref_mem[idx];
`ifdef ERVP_REGFILE_BYPASS_EN
        if (wacc && idx == widx) v = merge(v, wd, perm);
        if (clr_pos >= 0 && clr_pos < DEPTH && idx == clr_pos) v = 32'h0;
`endif
        return v;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        clr_pos = -1;
        for (int p = 0; p < NUM_RPORT; p++) last_rd[p] = 32'h0;
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdata0"}, rdata_list_synch[31:0], 32'h0);
        chk({tag, "_rdata1"}, rdata_list_synch[63:32], 32'h0);
        chk({tag, "_rvalid"}, 32'(rvalid_list), 32'h0);
        chk({tag, "_busy"}, 32'(clear_busy), 32'h0);
        chk({tag, "_done"}, 32'(clear_done), 32'h0);
    endtask

    // Driver: one clock cycle of stimulus followed by checks of every output against the model
    task automatic do_cycle(input bit wen, input int widx, input logic [3:0] perm,
                            input logic [31:0] wd, input logic [1:0] ren,
                            input int ri0, input int ri1, input bit creq);
        bit wacc;
        int ri [NUM_RPORT];
        ri[0] = ri0;
        ri[1] = ri1;
        windex        = 3'(widx);
        wenable       = wen;
        wpermit       = perm;
        wdata         = wd;
        renable_list  = ren;
        rindex_list   = {3'(ri1), 3'(ri0)};
        clear_request = creq;
        wacc = (clr_pos < 0) && wen && (widx < DEPTH);
        for (int p = 0; p < NUM_RPORT; p++) begin
            if (ren[p]) exp_q.push_back(model_rd(ri[p], wacc, widx, perm, wd));
        end
        @(posedge clk);
        #1;
        cyc++;
        if (wacc) ref_mem[widx] = merge(ref_mem[widx], wd, perm);
        if (clr_pos >= 0) begin
            if (clr_pos < DEPTH) ref_mem[clr_pos] = 32'h0;
            clr_pos++;
            if (clr_pos > DEPTH) clr_pos = -1;
        end else if (creq) begin
            clr_pos = 0;
        end
        for (int p = 0; p < NUM_RPORT; p++) begin
            chk($sformatf("rvalid%0d", p), 32'(rvalid_list[p]), 32'(ren[p]));
            if (ren[p]) last_rd[p] = exp_q.pop_front();
            chk($sformatf("rdata%0d", p), rdata_list_synch[32*p +: 32], last_rd[p]);
        end
        chk("wready", 32'(wready), 32'(clr_pos < 0));
        chk("clear_busy", 32'(clear_busy), 32'(clr_pos >= 0));
        chk("clear_done", 32'(clear_done), 32'(clr_pos == DEPTH));
    endtask

    task automatic idle_cycle();
        do_cycle(1'b0, 0, 4'h0, 32'h0, 2'b00, 0, 0, 1'b0);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1'b0, 0, 4'h0, 32'h0, 2'b11, i, DEPTH - 1 - i, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        windex = '0; wenable = 1'b0; wpermit = '0; wdata = '0;
        rindex_list = '0; renable_list = '0; clear_request = 1'b0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;
        #1;
        chk("por_wready", 32'(wready), 32'h1);

        // All entries zero after reset, both ports, then a no-read cycle holds data
        read_all();
        idle_cycle();

        // Masked write over an existing value
        do_cycle(1'b1, 3, 4'hF, 32'h11223344, 2'b00, 0, 0, 1'b0);
        do_cycle(1'b1, 3, 4'b0101, 32'hAABBCCDD, 2'b00, 0, 0, 1'b0);
        do_cycle(1'b0, 0, 4'h0, 32'h0, 2'b11, 3, 3, 1'b0);
        chk("masked_write", rdata_list_synch[31:0], 32'h11BB33DD);

        // Write and read of the same entry in one cycle
        do_cycle(1'b1, 5, 4'hF, 32'hCAFEF00D, 2'b01, 5, 0, 1'b0);
`ifdef ERVP_REGFILE_BYPASS_EN
        chk("same_cycle_rd", rdata_list_synch[31:0], 32'hCAFEF00D);
`else
        chk("same_cycle_rd", rdata_list_synch[31:0], 32'h00000000);
`endif
        do_cycle(1'b0, 0, 4'h0, 32'h0, 2'b10, 0, 5, 1'b0);

        // Out-of-range write and read
        do_cycle(1'b1, DEPTH, 4'hF, 32'hDEADBEEF, 2'b11, DEPTH, 7, 1'b0);
        chk("oor_read", rdata_list_synch[31:0], 32'h0);
        do_cycle(1'b1, 7, 4'hF, 32'hDEADBEEF, 2'b01, 7, 0, 1'b0);
        read_all();

        // Random traffic with occasional clears
        for (int k = 0; k < 200; k++) begin
            do_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 7), 4'($urandom_range(0, 15)),
                     $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 7),
                     $urandom_range(0, 7), ($urandom_range(0, 39) == 0));
        end
        while (clr_pos >= 0) idle_cycle();

        // Full clear with a write on the request cycle, rejected writes and a repeat request
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, i, 4'hF, $urandom | 32'h1, 2'b00, 0, 0, 1'b0);
        do_cycle(1'b1, 1, 4'hF, 32'h12345678, 2'b01, 1, 0, 1'b1);
        for (int k = 0; k <= DEPTH; k++) begin
            do_cycle(1'b1, $urandom_range(0, DEPTH - 1), 4'hF, $urandom, 2'b11,
                     k % DEPTH, $urandom_range(0, DEPTH - 1), (k == 2));
        end
        chk("clear_end_idle", 32'(clear_busy), 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1'b0, 0, 4'h0, 32'h0, 2'b01, i, 0, 1'b0);
            chk("cleared_entry", rdata_list_synch[31:0], 32'h0);
        end

        // Reset in the middle of a clear
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, i, 4'hF, $urandom, 2'b00, 0, 0, 1'b0);
        do_cycle(1'b0, 0, 4'h0, 32'h0, 2'b11, 4, 2, 1'b1);
        repeat (3) do_cycle(1'b0, 0, 4'h0, 32'h0, 2'b11, 5, 0, 1'b0);
        rst = 1'b1;
        #2;
        check_reset_outputs("mid_clear_rst");
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        #1;
        chk("post_rst_wready", 32'(wready), 32'h1);
        do_cycle(1'b1, 2, 4'hF, 32'h5A5AA5A5, 2'b00, 0, 0, 1'b0);
        repeat (DEPTH + 2) do_cycle(1'b0, 0, 4'h0, 32'h0, 2'b11, 2, 4, 1'b0);
        read_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ervp_register_file_mr1w_clear.md
ERVP_REGISTER_FILE_MR1W_CLEAR -- requirements
Module: ervp_register_file_mr1w_clear

Interface
REQ-001 Parameter DEPTH, default 8, number of entries (>=2).
REQ-002 Parameter WIDTH, default 32, entry width in bits.
REQ-003 Parameter BW_INDEX, default 3, index width; must satisfy 2**BW_INDEX >= DEPTH.
REQ-004 Parameter NUM_RPORT, default 2, number of independent synchronous read ports (>=1).
REQ-005 Parameter BW_SUBWORD, default 8, write-mask granularity; NUM_SUBWORD = ceil(WIDTH/BW_SUBWORD).
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 windex  input  BW_INDEX  write entry index.
REQ-009 wenable  input  1  write request.
REQ-010 wpermit  input  NUM_SUBWORD  per-subword write mask, bit i covers bits [BW_SUBWORD*(i+1)-1 -: BW_SUBWORD].
REQ-011 wdata  input  WIDTH  write data.
REQ-012 wready  output  1  write accepted this cycle.
REQ-013 rindex_list  input  NUM_RPORT*BW_INDEX  per-port read index, port p at [BW_INDEX*(p+1)-1 -: BW_INDEX].
REQ-014 renable_list  input  NUM_RPORT  per-port read request.
REQ-015 rdata_list_synch  output  NUM_RPORT*WIDTH  per-port registered read data.
REQ-016 rvalid_list  output  NUM_RPORT  per-port read-data-valid pulse.
REQ-017 clear_request  input  1  start background clear of all entries.
REQ-018 clear_busy  output  1  clear sequence in progress.
REQ-019 clear_done  output  1  one-cycle pulse at clear completion.

Function
REQ-020 Write occurs iff wenable=1 and wready=1; only subwords with wpermit[i]=1 are updated; wenable=0 writes nothing.
REQ-021 Write with windex >= DEPTH shall be ignored (no entry changes, wready unaffected).
REQ-022 Read port p with renable_list[p]=1 at edge N shall drive rdata of entry rindex_p and rvalid_list[p]=1 after edge N; latency exactly 1 cycle; all ports independent, any index overlap allowed.
REQ-023 renable_list[p]=0: rdata for port p holds previous value, rvalid_list[p]=0.
REQ-024 Read with rindex_p >= DEPTH shall return 0 with rvalid_list[p]=1.
REQ-025 Clear FSM states IDLE, CLEAR, DONE; IDLE->CLEAR on clear_request=1; CLEAR writes 0 to entry cnt, cnt increments each cycle; cnt=DEPTH-1 -> DONE; DONE -> IDLE unconditionally.
REQ-026 Clear takes exactly DEPTH cycles in CLEAR plus 1 in DONE; clear_busy=1 in CLEAR and DONE; clear_done=1 only in DONE.
REQ-027 wready=1 only in IDLE; a write in the same cycle as clear_request is accepted and later cleared.
REQ-028 clear_request in CLEAR or DONE shall be ignored (no restart, no queueing).
REQ-029 Reads during clear are permitted and return current array contents (already-cleared entries read 0).
REQ-030 Read of an entry written in the same cycle without bypass returns pre-write contents.

Reset
REQ-031 rst=1 shall immediately set all entries to 0, rdata_list_synch=0, rvalid_list=0, FSM=IDLE, cnt=0, clear_busy=0, clear_done=0; wready=1 after release.
REQ-032 rst asserted mid-clear aborts the sequence; no clear_done pulse.

Configuration
REQ-033 Macro ERVP_REGFILE_BYPASS_EN defined: a read whose index equals an accepted same-cycle windex returns old contents merged with wdata on permitted subwords; also a read of entry cnt during CLEAR returns 0.
REQ-034 Macro ERVP_REGFILE_BYPASS_EN undefined: no forwarding; REQ-030 applies; area excludes bypass muxes.

Verification
REQ-035 Reset, then read all DEPTH entries on every port -> all rdata 0, rvalid 1 cycle after each renable.
REQ-036 Write windex=3, wdata=0xAABBCCDD, wpermit=4'b0101 over 0x11223344 -> later read returns 0x11BB33DD.
REQ-037 Same-cycle write windex=5 data 0xCAFEF00D (wpermit all 1, old 0) and read port 0 index 5 -> 0xCAFEF00D with ERVP_REGFILE_BYPASS_EN, 0x00000000 without.
REQ-038 Fill all entries, pulse clear_request -> clear_busy high DEPTH+1 cycles, wready 0, clear_done pulse at cycle DEPTH+1, all entries read 0; second clear_request mid-sequence ignored.
REQ-039 Assert rst at CLEAR cycle 3 -> outputs at reset values, no clear_done, writes accepted next cycle.
REQ-040 Write windex=DEPTH and read rindex=DEPTH -> no entry changes, read returns 0 with rvalid 1.
